puf_measure_ctrl: RTL and testbench
===================================

PUF_MEASURE_CTRL -- requirements
Module: puf_measure_ctrl

Interface
REQ-001 SHALL have parameter WIN_W, default 16: width of window_len and of the internal window counter.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum number of clk cycles spent in WAIT_DONE.
REQ-003 SHALL have port clk, input, 1 bit: the only clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request for one measurement run.
REQ-006 SHALL have port window_len, input, WIN_W bits: count window in clk cycles; 0 is treated as 1.
REQ-007 SHALL have port num_bits, input, 6 bits: response bits per run, 1..32; 0 and any value above 32 are treated as 32.
REQ-008 SHALL have port margin_thr, input, 8 bits: minimum |cnt_a-cnt_b| for a bit to count as stable.
REQ-009 SHALL have port cnt_clear, output, 1 bit: clear strobe to both ring-oscillator counters.
REQ-010 SHALL have port cnt_ctrl, output, 1 bit: count enable to both counters.
REQ-011 SHALL have port cnt_done, input, 1 bit: single-clk pulse from the counters after cnt_ctrl falls.
REQ-012 SHALL have ports cnt_a and cnt_b, input, 32 bits each: the two counter values.
REQ-013 SHALL have port ro_sel, output, 5 bits: current bit index, used to select the RO pair.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port resp, output, 32 bits: response word; bit i holds the result for ro_sel=i.
REQ-017 SHALL have port unstable, output, 32 bits: per-bit low-margin flags.
REQ-018 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-019 SHALL register all outputs, and SHALL implement FSM states IDLE, CLEAR, COUNT, WAIT_DONE, COMPARE and FINISH.
REQ-020 In IDLE, start=1 SHALL do all of the following: latch window_len and num_bits; set idx=0; clear resp, unstable and err; go to CLEAR. start outside IDLE SHALL be ignored.
REQ-021 CLEAR SHALL last 1 cycle with cnt_clear=1 and cnt_ctrl=0, then go to COUNT.
REQ-022 COUNT SHALL hold cnt_ctrl=1 for exactly W consecutive cycles, where W is the latched window length, then go to WAIT_DONE.
REQ-023 In WAIT_DONE, cnt_ctrl SHALL be 0; cnt_done=1 SHALL cause a transition to COMPARE.
REQ-024 If cnt_done does not arrive within TIMEOUT cycles of entering WAIT_DONE, the block SHALL set err=1 and go to FINISH, leaving resp bits not yet measured at 0.
REQ-025 cnt_done SHALL be ignored in every state except WAIT_DONE.
REQ-026 COMPARE SHALL set resp[idx] = (cnt_a > cnt_b), unsigned; equal values SHALL give 0.
REQ-027 After COMPARE, if idx equals N-1 the FSM SHALL go to FINISH; otherwise idx SHALL increment and the FSM SHALL go to CLEAR.
REQ-028 FINISH SHALL pulse resp_valid for 1 cycle, then go to IDLE; resp, unstable and err SHALL hold their values until the next accepted start.
REQ-029 ro_sel SHALL equal idx throughout the run.
REQ-030 Cycle count per bit SHALL be 1 + W + D + 1, where D is the number of WAIT_DONE cycles up to and including the cnt_done cycle.
REQ-031 The window counter SHALL be WIN_W bits wide and SHALL never wrap; window_len = 2^WIN_W-1 SHALL yield exactly that many cycles.

Reset
REQ-032 When rst=1, the block SHALL asynchronously force state IDLE, idx=0, window counter 0, timeout counter 0, and all outputs to 0.
REQ-033 Assertion of rst mid-run SHALL abort the run with no resp_valid pulse; after release, the block SHALL wait for a new start.

Configuration
REQ-034 With macro PUF_MARGIN_CHECK_EN defined, COMPARE SHALL set unstable[idx] = (|cnt_a-cnt_b| < margin_thr), computed as a 32-bit unsigned difference with no overflow.
REQ-035 With PUF_MARGIN_CHECK_EN undefined, unstable SHALL be constant 0 and margin_thr SHALL be ignored; both ports SHALL remain present.

Verification
REQ-036 Scenario: num_bits=4, window_len=10, cnt_done 1 cycle after cnt_ctrl falls, (cnt_a, cnt_b) per bit = (100,90), (50,60), (7,7), (9,8) -> resp=0x9, resp_valid once, cnt_ctrl high exactly 10 cycles per bit, 13 cycles per bit.
REQ-037 Scenario: window_len=0, num_bits=0 -> 32 bits measured, cnt_ctrl high 1 cycle per bit, ro_sel walks 0..31.
REQ-038 Scenario: cnt_done never asserted -> err=1 after 15 WAIT_DONE cycles, resp_valid pulse, resp=0.
REQ-039 Scenario: start pulsed again while busy, and a cnt_done pulse injected during COUNT -> no effect on sequence or results.
REQ-040 Scenario: rst asserted during COUNT of bit 2 -> all outputs 0 immediately, no resp_valid; a subsequent start runs cleanly.
REQ-041 Scenario: with PUF_MARGIN_CHECK_EN, margin_thr=5, (cnt_a, cnt_b) = (100,97), (200,100) -> unstable=0x1, resp=0x3; without the macro -> unstable=0.

Source files
------------

// File: rtl/puf_measure_ctrl.sv
// PUF measurement controller: sequences clear/count/wait/compare for each
// ring-oscillator pair and assembles the response word bit by bit.
// Optional feature macro: PUF_MARGIN_CHECK_EN (per-bit low-margin flags in unstable).
module puf_measure_ctrl #(
    parameter int WIN_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    input  logic [5:0]       num_bits,
    input  logic [7:0]       margin_thr,
    output logic             cnt_clear,
    output logic             cnt_ctrl,
    input  logic             cnt_done,
    input  logic [31:0]      cnt_a,
    input  logic [31:0]      cnt_b,
    output logic [4:0]       ro_sel,
    output logic             busy,
    output logic             resp_valid,
    output logic [31:0]      resp,
    output logic [31:0]      unstable,
    output logic             err
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StCount,
        StWaitDone,
        StCompare,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [4:0]       last_idx_q;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    logic             cnt_clear_d, cnt_ctrl_d, busy_d, resp_valid_d, err_d;
    logic [31:0]      resp_d, unstable_d;

`ifdef PUF_MARGIN_CHECK_EN
    logic [31:0] diff;
    assign diff = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
`else
    logic unused_margin;
    assign unused_margin = ^margin_thr;
`endif

    // State, index and counter registers; run parameters latched on accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            last_idx_q <= '0;
            win_len_q  <= '0;
            win_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            win_cnt_q <= win_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            if (state_q == StIdle && start) begin
                // Zero window means one cycle; out-of-range bit counts mean 32
                win_len_q  <= (window_len == '0) ? WIN_W'(1) : window_len;
                last_idx_q <= (num_bits == 6'd0 || num_bits > 6'd32) ? 5'd31
                                                                     : 5'(num_bits - 6'd1);
            end
        end
    end

    // Next-state, bit index and cycle counters
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (start) state_d = StClear;
            StClear:    state_d = StCount;
            StCount:    if (win_cnt_q == win_len_q - WIN_W'(1)) state_d = StWaitDone;
            StWaitDone: begin
                if (cnt_done) begin
                    state_d = StCompare;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = StFinish;
                end
            end
            StCompare:  state_d = (idx_q == last_idx_q) ? StFinish : StClear;
            StFinish:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase

        idx_d = idx_q;
        if (state_q == StIdle && start) begin
            idx_d = '0;
        end else if (state_q == StCompare && state_d == StClear) begin
            idx_d = idx_q + 5'd1;
        end

        // Counters only run while staying in their state, so they never wrap
        win_cnt_d = (state_q == StCount && state_d == StCount) ? win_cnt_q + WIN_W'(1) : '0;
        tmo_cnt_d = (state_q == StWaitDone && state_d == StWaitDone) ? tmo_cnt_q + TMO_W'(1)
                                                                     : '0;
    end

    // Next values of the registered outputs
    always_comb begin
        cnt_clear_d  = (state_d == StClear);
        cnt_ctrl_d   = (state_d == StCount);
        busy_d       = (state_d != StIdle);
        resp_valid_d = (state_d == StFinish);
        resp_d       = resp;
        unstable_d   = unstable;
        err_d        = err;
        if (state_q == StIdle && start) begin
            resp_d     = '0;
            unstable_d = '0;
            err_d      = 1'b0;
        end
        if (state_q == StCompare) begin
            resp_d[idx_q] = (cnt_a > cnt_b);
`ifdef PUF_MARGIN_CHECK_EN
            unstable_d[idx_q] = (diff < {24'd0, margin_thr});
`endif
        end
        if (state_q == StWaitDone && state_d == StFinish) begin
            err_d = 1'b1;
        end
`ifndef PUF_MARGIN_CHECK_EN
        unstable_d = '0;
`endif
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_clear  <= 1'b0;
            cnt_ctrl   <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            ro_sel     <= '0;
            resp       <= '0;
            unstable   <= '0;
            err        <= 1'b0;
        end else begin
            cnt_clear  <= cnt_clear_d;
            cnt_ctrl   <= cnt_ctrl_d;
            busy       <= busy_d;
            resp_valid <= resp_valid_d;
            ro_sel     <= idx_d;
            resp       <= resp_d;
            unstable   <= unstable_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_puf_measure_ctrl.sv
// Self-checking bench for puf_measure_ctrl: directed scenarios plus randomized runs,
// each checked against a bit-level model of the measurement sequence.
module tb_puf_measure_ctrl;

    localparam int WIN_W   = 8;
    localparam int TIMEOUT = 15;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIN_W-1:0] window_len;
    logic [5:0]       num_bits;
    logic [7:0]       margin_thr;
    logic             cnt_clear;
    logic             cnt_ctrl;
    logic             cnt_done;
    logic [31:0]      cnt_a;
    logic [31:0]      cnt_b;
    logic [4:0]       ro_sel;
    logic             busy;
    logic             resp_valid;
    logic [31:0]      resp;
    logic [31:0]      unstable;
    logic             err;

    int checks = 0;
    int errors = 0;

    logic [31:0] va [32];
    logic [31:0] vb [32];

    puf_measure_ctrl #(
        .WIN_W  (WIN_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .window_len(window_len),
        .num_bits  (num_bits),
        .margin_thr(margin_thr),
        .cnt_clear (cnt_clear),
        .cnt_ctrl  (cnt_ctrl),
        .cnt_done  (cnt_done),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
        .ro_sel    (ro_sel),
        .busy      (busy),
        .resp_valid(resp_valid),
        .resp      (resp),
        .unstable  (unstable),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no end of test, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int eff_w(input int wl);
        return (wl == 0) ? 1 : wl;
    endfunction

    function automatic int eff_n(input int nb);
        return (nb == 0 || nb > 32) ? 32 : nb;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 32; i++) begin
            va[i] = $urandom;
            case ($urandom_range(0, 3))
                0:       vb[i] = va[i];
                1:       vb[i] = va[i] + 32'($urandom_range(0, 8));
                2:       vb[i] = va[i] - 32'($urandom_range(0, 8));
                default: vb[i] = $urandom;
            endcase
        end
    endtask

    // One measurement run. dly: WAIT_DONE cycle in which cnt_done arrives (0 = never).
    // rst_bit >= 0 aborts the run with reset during COUNT of that bit.
    task automatic run_meas(input string tag, input int wl, input int nb, input int dly,
                            input int thr, input bit inject, input int rst_bit);
        int          w, n, exp_bits, exp_len, bit_i, bit_cyc, ctrl_cnt, wd, budget;
        bit          prev_ctrl, done_seen, busy_bad, post_rst_bad;
        bit          exp_err;
        logic [31:0] exp_resp, exp_unst;
`ifdef PUF_MARGIN_CHECK_EN
        longint      d;
`endif
        w = eff_w(wl);
        n = eff_n(nb);
        exp_resp = '0;
        exp_unst = '0;
        if (dly == 0) begin
            exp_err  = 1'b1;
            exp_bits = 1;
            exp_len  = 1 + w + TIMEOUT;
        end else begin
            exp_err  = 1'b0;
            exp_bits = n;
            exp_len  = 1 + w + dly + 1;
            for (int i = 0; i < n; i++) begin
                exp_resp[i] = (va[i] > vb[i]);
`ifdef PUF_MARGIN_CHECK_EN
                d = longint'(va[i]) - longint'(vb[i]);
                if (d < 0) d = -d;
                exp_unst[i] = (d < longint'(thr));
`endif
            end
        end
        margin_thr = 8'(thr);

        @(negedge clk);
        window_len = WIN_W'(wl);
        num_bits   = 6'(nb);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        // Scramble the run parameters to prove they were latched
        window_len = WIN_W'($urandom);
        num_bits   = 6'($urandom);
        check({tag, "/start_busy"}, busy, 1);
        check({tag, "/start_resp_clr"}, {err, resp}, 0);

        bit_i = -1; bit_cyc = 0; ctrl_cnt = 0; wd = 0;
        prev_ctrl = 1'b0; done_seen = 1'b0; busy_bad = 1'b0;
        budget = exp_bits * exp_len + 10;
        for (int cyc = 0; cyc < budget; cyc++) begin
            cnt_done = 1'b0;
            start    = 1'b0;
            if (!busy) busy_bad = 1'b1;
            if ((cnt_clear || resp_valid) && bit_i >= 0) begin
                check({tag, "/bit_len"}, bit_cyc, exp_len);
                check({tag, "/ctrl_len"}, ctrl_cnt, w);
            end
            if (cnt_clear) begin
                bit_i++;
                check({tag, "/ro_sel"}, ro_sel, bit_i);
                bit_cyc  = 0;
                ctrl_cnt = 0;
            end
            if (resp_valid) begin
                done_seen = 1'b1;
                break;
            end
            bit_cyc++;
            if (cnt_ctrl) ctrl_cnt++;
            cnt_a = va[ro_sel];
            cnt_b = vb[ro_sel];
            if (prev_ctrl && !cnt_ctrl) wd = dly;
            if (wd > 0) begin
                wd--;
                if (wd == 0) cnt_done = 1'b1;
            end
            if (inject && cnt_ctrl && $urandom_range(0, 1) == 1) begin
                start    = 1'b1;
                cnt_done = 1'b1;
            end
            if (rst_bit >= 0 && bit_i == rst_bit && cnt_ctrl) begin
                rst = 1'b1;
                #1;
                check({tag, "/rst_ctrl"},
                      {cnt_clear, cnt_ctrl, busy, resp_valid, err, ro_sel}, 0);
                check({tag, "/rst_resp"}, resp, 0);
                check({tag, "/rst_unst"}, unstable, 0);
                @(negedge clk);
                rst          = 1'b0;
                start        = 1'b0;
                cnt_done     = 1'b0;
                post_rst_bad = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (busy || resp_valid) post_rst_bad = 1'b1;
                end
                check({tag, "/idle_after_rst"}, post_rst_bad, 0);
                return;
            end
            prev_ctrl = cnt_ctrl;
            @(negedge clk);
        end
        cnt_done = 1'b0;
        start    = 1'b0;

        check({tag, "/resp_valid_seen"}, done_seen, 1);
        if (done_seen) begin
            check({tag, "/resp"}, resp, exp_resp);
            check({tag, "/unstable"}, unstable, exp_unst);
            check({tag, "/err"}, err, exp_err);
            check({tag, "/bits"}, bit_i + 1, exp_bits);
            check({tag, "/busy_run"}, busy_bad, 0);
            @(negedge clk);
            check({tag, "/pulse_end"}, {resp_valid, busy}, 0);
            check({tag, "/hold"}, {err, resp}, {exp_err, exp_resp});
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cnt_done   = 1'b0;
        window_len = '0;
        num_bits   = '0;
        margin_thr = '0;
        cnt_a      = '0;
        cnt_b      = '0;
        for (int i = 0; i < 32; i++) begin
            va[i] = '0;
            vb[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("reset_outputs", {cnt_clear, cnt_ctrl, busy, resp_valid, err, ro_sel}, 0);
        check("reset_resp", {unstable, resp}, 0);
        rst = 1'b0;

        // Basic 4-bit run, includes equal counts
        va[0] = 100; vb[0] = 90;
        va[1] = 50;  vb[1] = 60;
        va[2] = 7;   vb[2] = 7;
        va[3] = 9;   vb[3] = 8;
        run_meas("basic", 10, 4, 1, 0, 1'b0, -1);
        check("basic_word", resp, 32'h9);

        // Zero window and zero bit count
        fill_random();
        run_meas("zeros", 0, 0, 1, 0, 1'b0, -1);

        // Counters never report done
        run_meas("timeout", 3, 5, 0, 0, 1'b0, -1);

        // cnt_done on the last allowed WAIT_DONE cycle
        fill_random();
        run_meas("done_last", 2, 2, TIMEOUT, 0, 1'b0, -1);

        // Spurious start and cnt_done during COUNT
        fill_random();
        run_meas("inject", 4, 6, 2, 4, 1'b1, -1);

        // Reset during bit 2, then a clean run
        fill_random();
        run_meas("abort", 5, 4, 1, 0, 1'b0, 2);
        run_meas("after_rst", 5, 4, 1, 0, 1'b0, -1);

        // Margin flags
        va[0] = 100; vb[0] = 97;
        va[1] = 200; vb[1] = 100;
        run_meas("margin", 3, 2, 1, 5, 1'b0, -1);
`ifdef PUF_MARGIN_CHECK_EN
        check("margin_word", {unstable, resp}, {32'h1, 32'h3});
`else
        check("margin_word", {unstable, resp}, {32'h0, 32'h3});
`endif

        // Largest window and an out-of-range bit count
        fill_random();
        run_meas("win_max", (1 << WIN_W) - 1, 1, 1, 0, 1'b0, -1);
        run_meas("nb_over", 1, 40, 3, 0, 1'b0, -1);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_meas("random", $urandom_range(0, 12), $urandom_range(0, 63),
                     $urandom_range(1, TIMEOUT), $urandom_range(0, 255), 1'($urandom), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
